// File: rtl/tri_queue.sv
// Triangle input queue between the triangle source and bounding-box stage.
// Ring buffer with explicit occupancy count; full/empty come from count only.
module tri_queue #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R10S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R10U [COLORS],
  input  logic                     validTri_R10H,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R11S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R11U [COLORS],
  output logic                     validTri_R11H,
  input  logic                     haltBox_RnnnnL,
  output logic [$clog2(DEPTH):0]   count_R11U
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic signed [SIGFIG-1:0] tri_mem [DEPTH][VERTS][AXIS];
  logic        [SIGFIG-1:0] col_mem [DEPTH][COLORS];

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign halt_RnnnnL   = (count != FULL);
  assign validTri_R11H = (count != '0);
  assign count_R11U    = count;

  assign push = validTri_R10H & halt_RnnnnL;
  assign pop  = validTri_R11H & haltBox_RnnnnL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      unique case (1'b1)
        (push && !pop): count <= count + CW'(1);
        (pop && !push): count <= count - CW'(1);
        default:        count <= count;
      endcase
    end
  end

  // Storage is deliberately unreset; the output gate hides stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      tri_mem[wp] <= tri_R10S;
      col_mem[wp] <= color_R10U;
    end
  end

  always_comb begin
    for (int v = 0; v < VERTS; v++) begin
      for (int a = 0; a < AXIS; a++) begin
        tri_R11S[v][a] = validTri_R11H ? tri_mem[rp][v][a] : '0;
      end
    end
    for (int c = 0; c < COLORS; c++) begin
      color_R11U[c] = validTri_R11H ? col_mem[rp][c] : '0;
    end
  end

endmodule
